adc_sample_scheduler: RTL and testbench

Time-shares the single external ADC, with its front-end mux on `ADC_SEL`, among up to `NUM_SRC` sample requesters, such as AA-cell and Li-cell battery sensing.
- Runs a fixed sample cadence; each slot is handed to one requester by round-robin.
- Per granted slot: drives the mux, waits for analog settle, pulses the ADC request, then collects the result or times out.
- Sits between the board-support monitor logic and the ADC handshake (`hAdcReq_ext` / `hAdcReady_r1` / `hAdcValue_r1`).
- Replaces free-running mux toggling with deterministic, tagged samples.

---
 rtl/adc_sample_scheduler.sv | 273 +++++++++++++++++++++++++++
 tb/tb_adc_sample_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_scheduler.sv
// ---------------------------------------------------------------------------
// adc_sample_scheduler
//
// Shares one external ADC and its analog front-end mux among NUM_SRC sample
// requesters. A free-running slot timer sets a pending flag once per slot
// period. Each pending slot goes to one requesting source, picked round-robin.
// A granted slot does the following in order:
//   1. drives the mux select for that source;
//   2. waits for the analog path to settle, unless the select did not change;
//   3. pulses the ADC start request;
//   4. collects the conversion result, or gives up after a timeout.
// Each finished slot produces a one-cycle result strobe tagged with the
// source index.
//
// Ports
//   clk             system clock
//   reset           synchronous, active-high reset
//   enable          permits new grants; a slot already granted always completes
//   src_req         level request per source
//   src_mux_sel     packed mux value per source (source i at [i*MUX_W +: MUX_W])
//   hAdcReady_r1    ADC conversion done (one-cycle pulse)
//   hAdcValue_r1    ADC result, valid with hAdcReady_r1
//   ADC_SEL         external mux select; holds its value between slots
//   hAdcReq_ext     ADC start pulse
//   busy            a slot is in progress
//   result_valid    one-cycle result strobe
//   result_src      source index of the latest result
//   result_value    latest sample, 0 when the slot timed out
//   result_timeout  latest slot ended by timeout
// ---------------------------------------------------------------------------
module adc_sample_scheduler #(
  parameter int NUM_SRC         = 2,
  parameter int MUX_W           = 1,
  parameter int INTERVAL_CYCLES = 41946,
  parameter int SETTLE_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic [NUM_SRC*MUX_W-1:0]   src_mux_sel,
  input  logic                       hAdcReady_r1,
  input  logic [13:0]                hAdcValue_r1,
  output logic [MUX_W-1:0]           ADC_SEL,
  output logic                       hAdcReq_ext,
  output logic                       busy,
  output logic                       result_valid,
  output logic [$clog2(NUM_SRC)-1:0] result_src,
  output logic [13:0]                result_value,
  output logic                       result_timeout
);

  localparam int SRC_W  = $clog2(NUM_SRC);
  localparam int SLOT_W = $clog2(INTERVAL_CYCLES + 1);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(INTERVAL_CYCLES - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_REQ    = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Source index (base + offs) wrapped into 0..NUM_SRC-1; offs < NUM_SRC.
  function automatic logic [SRC_W-1:0] rot_idx(input logic [SRC_W-1:0] base,
                                               input int offs);
    int sum_v;
    sum_v = int'(base) + offs;
    return SRC_W'((sum_v >= NUM_SRC) ? (sum_v - NUM_SRC) : sum_v);
  endfunction

  // State and counters
  logic [2:0]        state_r;
  logic [2:0]        state_nx_s;
  logic [SLOT_W-1:0] slot_cnt_r;
  logic              slot_pending_r;
  logic [SET_W-1:0]  settle_cnt_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [SRC_W-1:0]  rr_ptr_r;
  logic [SRC_W-1:0]  cur_r;

  // Registered outputs
  logic [MUX_W-1:0]  adc_sel_r;
  logic              result_valid_r;
  logic [SRC_W-1:0]  result_src_r;
  logic [13:0]       result_value_r;
  logic              result_timeout_r;

  // Combinational decode
  logic [MUX_W-1:0]  mux_tab_s [NUM_SRC];
  logic [SRC_W-1:0]  pick_s;
  logic              pick_found_s;
  logic              grant_s;
  logic              bypass_s;
  logic              wrap_s;
  logic              settle_done_s;
  logic              to_done_s;
  logic              finish_s;

  // Unpack the per-source mux values into an indexable table.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_mux_tab
    assign mux_tab_s[gi] = src_mux_sel[gi*MUX_W +: MUX_W];
  end

  assign wrap_s        = (slot_cnt_r == SLOT_LAST);
  assign settle_done_s = (settle_cnt_r == SETTLE_LAST);
  assign to_done_s     = (to_cnt_r == TO_LAST);
  assign grant_s       = (state_r == ST_IDLE) && enable && slot_pending_r && pick_found_s;
  // No settle wait is needed when the analog path is already on this input.
  assign bypass_s      = (mux_tab_s[pick_s] == adc_sel_r);
  // A ready inside the wait window wins over a timeout in the same cycle.
  assign finish_s      = (state_r == ST_WAIT) && (hAdcReady_r1 || to_done_s);

  // Round-robin search: the lowest offset from rr_ptr_r with a request wins,
  // so scan from the highest offset down and let later hits overwrite.
  always_comb begin
    pick_s       = rr_ptr_r;
    pick_found_s = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (src_req[rot_idx(rr_ptr_r, k)]) begin
        pick_s       = rot_idx(rr_ptr_r, k);
        pick_found_s = 1'b1;
      end else begin
        pick_s       = pick_s;
        pick_found_s = pick_found_s;
      end
    end
  end

  // Slot sequencing: next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nx_s = bypass_s ? ST_REQ : ST_SETTLE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_done_s) begin
          state_nx_s = ST_REQ;
        end else begin
          state_nx_s = ST_SETTLE;
        end
      end
      ST_REQ: begin
        state_nx_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (finish_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Slot sequencing: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Free-running slot timer and the pending-slot flag. A wrap in the same
  // cycle as a grant re-arms the flag, so the wrap takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_r     <= {SLOT_W{1'b0}};
      slot_pending_r <= 1'b0;
    end else begin
      if (wrap_s) begin
        slot_cnt_r <= {SLOT_W{1'b0}};
      end else begin
        slot_cnt_r <= slot_cnt_r + 1'b1;
      end
      if (wrap_s) begin
        slot_pending_r <= 1'b1;
      end else if (grant_s) begin
        slot_pending_r <= 1'b0;
      end else begin
        slot_pending_r <= slot_pending_r;
      end
    end
  end

  // Settle and timeout counters. Each runs only in its own state and is
  // zero everywhere else, so entering the state always starts from 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt_r <= {SET_W{1'b0}};
      to_cnt_r     <= {TO_W{1'b0}};
    end else begin
      if ((state_r == ST_SETTLE) && !settle_done_s) begin
        settle_cnt_r <= settle_cnt_r + 1'b1;
      end else begin
        settle_cnt_r <= {SET_W{1'b0}};
      end
      if ((state_r == ST_WAIT) && !to_done_s) begin
        to_cnt_r <= to_cnt_r + 1'b1;
      end else begin
        to_cnt_r <= {TO_W{1'b0}};
      end
    end
  end

  // Grant latch (source and mux select), round-robin pointer and results.
  // Source and select are latched once at the grant, so later changes on
  // src_req / src_mux_sel cannot disturb a slot in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_r            <= {SRC_W{1'b0}};
      rr_ptr_r         <= {SRC_W{1'b0}};
      adc_sel_r        <= {MUX_W{1'b0}};
      result_valid_r   <= 1'b0;
      result_src_r     <= {SRC_W{1'b0}};
      result_value_r   <= 14'd0;
      result_timeout_r <= 1'b0;
    end else begin
      if (grant_s) begin
        cur_r     <= pick_s;
        adc_sel_r <= mux_tab_s[pick_s];
      end else begin
        cur_r     <= cur_r;
        adc_sel_r <= adc_sel_r;
      end

      if (state_r == ST_DONE) begin
        rr_ptr_r <= rot_idx(cur_r, 1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end

      // Results are staged on the WAIT->DONE edge so the strobe is high
      // exactly during DONE.
      result_valid_r <= finish_s;
      if (finish_s) begin
        result_src_r     <= cur_r;
        result_value_r   <= hAdcReady_r1 ? hAdcValue_r1 : 14'd0;
        result_timeout_r <= !hAdcReady_r1;
      end else begin
        result_src_r     <= result_src_r;
        result_value_r   <= result_value_r;
        result_timeout_r <= result_timeout_r;
      end
    end
  end

  assign ADC_SEL        = adc_sel_r;
  assign hAdcReq_ext    = (state_r == ST_REQ);
  assign busy           = (state_r != ST_IDLE);
  assign result_valid   = result_valid_r;
  assign result_src     = result_src_r;
  assign result_value   = result_value_r;
  assign result_timeout = result_timeout_r;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for adc_sample_scheduler.
// A behavioural model describes each slot as a timeline in absolute cycle
// numbers: the grant cycle, the request cycle and the response window. The
// model predicts every output on every cycle. Directed scenarios add literal
// cycle-number and value expectations, worked out by hand, that pin down the
// model itself.
// ---------------------------------------------------------------------------
module tb_adc_sample_scheduler;

  localparam int NS = 3;
  localparam int MW = 2;
  localparam int IV = 64;
  localparam int ST = 8;
  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  src_req;
  logic [5:0]  src_mux_sel;
  logic        hAdcReady_r1;
  logic [13:0] hAdcValue_r1;
  logic [1:0]  ADC_SEL;
  logic        hAdcReq_ext;
  logic        busy;
  logic        result_valid;
  logic [1:0]  result_src;
  logic [13:0] result_value;
  logic        result_timeout;

  adc_sample_scheduler #(
    .NUM_SRC(NS), .MUX_W(MW), .INTERVAL_CYCLES(IV),
    .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .src_req(src_req),
    .src_mux_sel(src_mux_sel), .hAdcReady_r1(hAdcReady_r1),
    .hAdcValue_r1(hAdcValue_r1), .ADC_SEL(ADC_SEL), .hAdcReq_ext(hAdcReq_ext),
    .busy(busy), .result_valid(result_valid), .result_src(result_src),
    .result_value(result_value), .result_timeout(result_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tcyc     = 0;   // cycles since the latest reset release

  // ADC responder / stray-ready injector state
  bit          resp_on    = 1'b0;
  int          resp_cnt   = 0;
  logic [13:0] resp_val   = 14'd0;
  int          inject_at  = -1;
  logic [13:0] inject_val = 14'd0;

  // ---------------- behavioural model ----------------
  int m_cyc, m_rr, m_cur, m_req_at;
  bit m_pend, m_busy, m_fin;
  int e_sel, e_src, e_val;
  bit e_req, e_busy, e_valid, e_to;

  function automatic int mux_of(input int i);
    int v;
    v = int'(src_mux_sel);
    return (v >> (MW * i)) & 3;
  endfunction

  function automatic bit req_of(input int i);
    int v;
    v = int'(src_req);
    return ((v >> i) & 1) != 0;
  endfunction

  // Model step: consumes the inputs of cycle m_cyc and yields the expected
  // outputs for cycle m_cyc+1.
  always @(posedge clk) begin : model
    int pick;
    bit found;
    int sel_new;
    if (reset) begin
      m_cyc = 0; m_rr = 0; m_cur = 0; m_req_at = 0;
      m_pend = 0; m_busy = 0; m_fin = 0;
      e_sel = 0; e_src = 0; e_val = 0; e_valid = 0; e_to = 0;
    end else begin
      e_valid = 0;
      if (m_fin) begin
        m_fin  = 0;
        m_busy = 0;
        m_rr   = (m_cur + 1) % NS;
      end else if (!m_busy) begin
        found = 0;
        pick  = 0;
        for (int k = 0; k < NS; k++) begin
          if (!found && req_of((m_rr + k) % NS)) begin
            found = 1;
            pick  = (m_rr + k) % NS;
          end
        end
        if (enable && m_pend && found) begin
          sel_new  = mux_of(pick);
          m_req_at = m_cyc + 1 + ((sel_new == e_sel) ? 0 : ST);
          e_sel    = sel_new;
          m_cur    = pick;
          m_busy   = 1;
          m_pend   = 0;
        end
      end else if (m_cyc > m_req_at) begin
        if (hAdcReady_r1) begin
          e_valid = 1; e_src = m_cur; e_val = int'(hAdcValue_r1); e_to = 0; m_fin = 1;
        end else if (m_cyc == m_req_at + TO) begin
          e_valid = 1; e_src = m_cur; e_val = 0; e_to = 1; m_fin = 1;
        end
      end
      if ((m_cyc % IV) == IV - 1) m_pend = 1;
      m_cyc++;
    end
    e_busy = m_busy;
    e_req  = m_busy && (m_cyc == m_req_at);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, tcyc, $time);
    end
  endtask

  task automatic cmp_model();
    chk("sel",     int'(ADC_SEL),        e_sel);
    chk("req",     int'(hAdcReq_ext),    int'(e_req));
    chk("busy",    int'(busy),           int'(e_busy));
    chk("valid",   int'(result_valid),   int'(e_valid));
    chk("src",     int'(result_src),     e_src);
    chk("value",   int'(result_value),   e_val);
    chk("timeout", int'(result_timeout), int'(e_to));
  endtask

  // One cycle: compare at the falling edge, then drive this cycle's inputs.
  task automatic tick();
    @(negedge clk);
    tcyc++;
    cmp_model();
    hAdcReady_r1 = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        hAdcReady_r1 = 1'b1;
        hAdcValue_r1 = resp_val;
      end
    end
    if (tcyc == inject_at) begin
      hAdcReady_r1 = 1'b1;
      hAdcValue_r1 = inject_val;
    end
    if (resp_on && hAdcReq_ext) resp_cnt = 5;
  endtask

  task automatic run_to(input int c);
    while (tcyc < c) tick();
  endtask

  // which: 0 = hAdcReq_ext, 1 = result_valid, 2 = busy
  task automatic wait_sig(input int which, input int budget, input string name, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      tick();
      if ((which == 0 && hAdcReq_ext) || (which == 1 && result_valid) || (which == 2 && busy))
        at = tcyc;
    end
    if (at < 0) chk({name, "_no_event"}, 0, 1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    resp_cnt = 0;
    inject_at = -1;
    hAdcReady_r1 = 1'b0;
    repeat (3) tick();
    chk("rst_sel",     int'(ADC_SEL),        0);
    chk("rst_req",     int'(hAdcReq_ext),    0);
    chk("rst_busy",    int'(busy),           0);
    chk("rst_valid",   int'(result_valid),   0);
    chk("rst_src",     int'(result_src),     0);
    chk("rst_value",   int'(result_value),   0);
    chk("rst_timeout", int'(result_timeout), 0);
    reset = 1'b0;
    tcyc  = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int at;
    int nb;
    reset        = 1'b1;
    enable       = 1'b1;
    src_req      = 3'b010;
    src_mux_sel  = {2'd3, 2'd2, 2'd1};
    hAdcReady_r1 = 1'b0;
    hAdcValue_r1 = 14'd0;

    // Single source with settle, then bypass
    resp_on = 1'b1; resp_val = 14'h1234;
    apply_reset();
    wait_sig(0, 100, "t1_req1", at);
    chk("t1_req1_cycle", at, 73);
    chk("t1_sel", int'(ADC_SEL), 2);
    wait_sig(1, 20, "t1_res1", at);
    chk("t1_res1_cycle", at, 79);
    chk("t1_res1_src", int'(result_src), 1);
    chk("t1_res1_value", int'(result_value), 'h1234);
    chk("t1_res1_timeout", int'(result_timeout), 0);
    wait_sig(0, 100, "t1_req2", at);
    chk("t1_req2_bypass_cycle", at, 129);
    wait_sig(1, 20, "t1_res2", at);
    chk("t1_res2_cycle", at, 135);

    // Round-robin over three requesters
    src_req = 3'b111;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      wait_sig(1, 100, "t2_res", at);
      chk("t2_rr_src", int'(result_src), k % 3);
      chk("t2_rr_cycle", at, 79 + 64 * k);
    end

    // Timeout, then a normal slot
    src_req = 3'b001; resp_on = 1'b0;
    apply_reset();
    wait_sig(1, 150, "t3_res1", at);
    chk("t3_to_cycle", at, 106);
    chk("t3_to_flag", int'(result_timeout), 1);
    chk("t3_to_value", int'(result_value), 0);
    chk("t3_to_src", int'(result_src), 0);
    resp_on = 1'b1; resp_val = 14'h2A5C;
    wait_sig(0, 100, "t3_req2", at);
    chk("t3_req2_cycle", at, 129);
    wait_sig(1, 20, "t3_res2", at);
    chk("t3_res2_cycle", at, 135);
    chk("t3_res2_flag", int'(result_timeout), 0);
    chk("t3_res2_value", int'(result_value), 'h2A5C);

    // Stray ready during settle, late ready in wait, request dropped in wait
    resp_on = 1'b0;
    apply_reset();
    inject_at = 68; inject_val = 14'h0AAA;
    wait_sig(0, 100, "t4_req", at);
    chk("t4_req_cycle", at, 73);
    inject_at = 80; inject_val = 14'h0155;
    run_to(76);
    src_req = 3'b000;
    wait_sig(1, 20, "t4_res", at);
    chk("t4_res_cycle", at, 81);
    chk("t4_res_value", int'(result_value), 'h0155);
    chk("t4_res_flag", int'(result_timeout), 0);
    chk("t4_res_src", int'(result_src), 0);

    // Enable held low across three wraps: one grant only, no backlog
    enable = 1'b0; src_req = 3'b001; resp_on = 1'b1; resp_val = 14'h0321;
    apply_reset();
    run_to(200);
    enable = 1'b1;
    wait_sig(2, 5, "t5_busy", at);
    chk("t5_grant_busy_cycle", at, 201);
    wait_sig(0, 20, "t5_req", at);
    chk("t5_req_cycle", at, 209);
    wait_sig(1, 20, "t5_res", at);
    chk("t5_res_cycle", at, 215);
    nb = 0;
    while (tcyc < 255) begin
      tick();
      if (busy) nb++;
    end
    chk("t5_no_backlog", nb, 0);
    src_req = 3'b000;
    run_to(270);
    chk("t5_idle_without_req", int'(busy), 0);
    src_req = 3'b100;
    tick();
    chk("t5_late_req_busy", int'(busy), 1);
    chk("t5_late_req_sel", int'(ADC_SEL), 3);
    wait_sig(0, 20, "t5_req2", at);
    chk("t5_req2_cycle", at, 279);
    wait_sig(1, 20, "t5_res2", at);
    chk("t5_res2_src", int'(result_src), 2);

    // Reset asserted during REQ
    enable = 1'b1; src_req = 3'b001; resp_on = 1'b0;
    apply_reset();
    wait_sig(0, 100, "t6_req", at);
    chk("t6_req_cycle", at, 73);
    reset = 1'b1;
    tick();
    chk("t6_req_after_reset", int'(hAdcReq_ext), 0);
    chk("t6_sel_after_reset", int'(ADC_SEL), 0);
    chk("t6_busy_after_reset", int'(busy), 0);
    chk("t6_valid_after_reset", int'(result_valid), 0);
    reset = 1'b0;
    tcyc  = 0;
    wait_sig(2, 100, "t6_regrant", at);
    chk("t6_regrant_busy_cycle", at, 65);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
